// File: rtl/minilab0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : minilab0_pkg
//  Description : Shared types, sizes, fill data and 7-segment glyph decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package minilab0_pkg;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] c_fill_a [DEPTH] = '{8'd5,  8'd10, 8'd15, 8'd20,
                                                       8'd25, 8'd30, 8'd35, 8'd40};
    localparam logic [DATA_W-1:0] c_fill_b [DEPTH] = '{8'd10, 8'd20, 8'd30, 8'd40,
                                                       8'd50, 8'd60, 8'd70, 8'd80};

    // Active-low glyphs, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo
//  Description : Synchronous first-word-fall-through FIFO; overflow and
//                underflow requests are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_wr;
    logic               w_do_rd;

    assign full    = (r_count == c_cnt_w'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;
    assign dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/minilab0.sv
`default_nettype none
// ============================================================================
//  Module      : minilab0
//  Description : Fills two FIFOs with constant data, multiply-accumulates
//                their contents and shows the 24-bit result on HEX5..HEX0.
//  Revision    : 1.0  initial release
// ============================================================================
module minilab0
    import minilab0_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       CLOCK2_50,
    input  logic       CLOCK3_50,
    input  logic       CLOCK4_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam int c_cnt_w  = $clog2(DEPTH);
    localparam int c_prod_w = 2 * DATA_W;

    logic                rst;
    state_t              r_state;
    logic [c_cnt_w-1:0]  r_fill_cnt;
    logic [c_cnt_w-1:0]  r_exec_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_a_head;
    logic [DATA_W-1:0]   w_b_head;
    logic                w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic [c_prod_w-1:0] w_prod;
    logic                w_show;
    logic                w_unused;

    assign rst      = ~KEY[0];
    assign w_unused = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1], SW[9:1],
                        w_a_full, w_a_empty, w_b_full, w_b_empty};

    assign w_wr_en = (r_state == FILL);
    assign w_rd_en = (r_state == EXEC);

    fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_a (
        .clk   (CLOCK_50),
        .rst   (rst),
        .wr_en (w_wr_en),
        .rd_en (w_rd_en),
        .din   (c_fill_a[r_fill_cnt]),
        .dout  (w_a_head),
        .full  (w_a_full),
        .empty (w_a_empty)
    );

    fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_b (
        .clk   (CLOCK_50),
        .rst   (rst),
        .wr_en (w_wr_en),
        .rd_en (w_rd_en),
        .din   (c_fill_b[r_fill_cnt]),
        .dout  (w_b_head),
        .full  (w_b_full),
        .empty (w_b_empty)
    );

    assign w_prod = c_prod_w'(w_a_head) * c_prod_w'(w_b_head);

    // Counters leave their state on the last element, so each phase lasts DEPTH cycles.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_exec_cnt <= '0;
            r_acc      <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_fill_cnt <= r_fill_cnt + c_cnt_w'(1);
                    if (r_fill_cnt == c_cnt_w'(DEPTH - 1)) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc      <= r_acc + {{(ACC_W - c_prod_w){1'b0}}, w_prod};
                    r_exec_cnt <= r_exec_cnt + c_cnt_w'(1);
                    if (r_exec_cnt == c_cnt_w'(DEPTH - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign w_show = (r_state == DONE) && SW[0];

    assign HEX0 = w_show ? seg7(r_acc[3:0])   : 7'h7F;
    assign HEX1 = w_show ? seg7(r_acc[7:4])   : 7'h7F;
    assign HEX2 = w_show ? seg7(r_acc[11:8])  : 7'h7F;
    assign HEX3 = w_show ? seg7(r_acc[15:12]) : 7'h7F;
    assign HEX4 = w_show ? seg7(r_acc[19:16]) : 7'h7F;
    assign HEX5 = w_show ? seg7(r_acc[23:20]) : 7'h7F;

    assign LEDR = {8'd0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_minilab0.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_minilab0
//  Description : Self-checking bench for minilab0 and its fifo sub-module.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_minilab0;

    logic       CLOCK_50  = 1'b0;
    logic       CLOCK2_50 = 1'b0;
    logic       CLOCK3_50 = 1'b0;
    logic       CLOCK4_50 = 1'b0;
    logic [3:0] KEY       = 4'b1110;
    logic [9:0] SW        = 10'd0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    logic       f_rst = 1'b1;
    logic       f_wr  = 1'b0;
    logic       f_rd  = 1'b0;
    logic [7:0] f_din = 8'd0;
    logic [7:0] f_dout;
    logic       f_full, f_empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  q_state [$];
    logic [41:0] q_hex   [$];
    logic [7:0]  q_fifo  [$];

    logic [23:0] acc_model;
    logic [41:0] hex_blank;
    logic [41:0] w_hex;

    always #10 CLOCK_50 = ~CLOCK_50;

    assign w_hex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    minilab0 u_dut (
        .CLOCK_50  (CLOCK_50),
        .CLOCK2_50 (CLOCK2_50),
        .CLOCK3_50 (CLOCK3_50),
        .CLOCK4_50 (CLOCK4_50),
        .KEY       (KEY),
        .SW        (SW),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .LEDR      (LEDR)
    );

    fifo #(.DEPTH(8), .DATA_W(8)) u_fifo (
        .clk   (CLOCK_50),
        .rst   (f_rst),
        .wr_en (f_wr),
        .rd_en (f_rd),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[n];
    endfunction

    function automatic logic [41:0] hex_of(input logic [23:0] a);
        return {glyph(a[23:20]), glyph(a[19:16]), glyph(a[15:12]),
                glyph(a[11:8]),  glyph(a[7:4]),   glyph(a[3:0])};
    endfunction

    function automatic logic [1:0] state_at(input int k);
        if (k <= 8)  return 2'd0;
        if (k <= 16) return 2'd1;
        return 2'd2;
    endfunction

    // Holds reset for the given cycles; caller is at posedge+1.
    task automatic hold_reset(input int cycles);
        KEY[0] = 1'b0;
        repeat (cycles) @(posedge CLOCK_50);
        #1;
        check("reset_ledr", 64'(LEDR), 64'd0);
        check("reset_hex", 64'(w_hex), 64'(hex_blank));
    endtask

    // Releases reset and tracks the state code for n cycles.
    task automatic release_track(input int n);
        KEY[0] = 1'b1;
        for (int k = 1; k <= n; k++) q_state.push_back({8'd0, state_at(k)});
        for (int k = 1; k <= n; k++) begin
            @(negedge CLOCK_50);
            check($sformatf("ledr_cycle%0d", k), 64'(LEDR), 64'(q_state.pop_front()));
        end
    endtask

    initial begin
        hex_blank = {6{7'h7F}};
        acc_model = '0;
        for (int i = 1; i <= 8; i++) acc_model += 24'((5 * i) * (10 * i));

        // First run: reset, fill, exec, done.
        @(posedge CLOCK_50); #1;
        hold_reset(2);
        release_track(17);
        check("done_sw0_blank", 64'(w_hex), 64'(hex_blank));
        SW[0] = 1'b1;
        q_hex.push_back(hex_of(acc_model));
        #1;
        check("done_sw1_digits", 64'(w_hex), 64'(q_hex.pop_front()));
        check("digits_literal", 64'(w_hex),
              64'({7'b1000000, 7'b1000000, 7'b0100100, 7'b1111000, 7'b0100001, 7'b0000000}));
        for (int k = 0; k < 3; k++) begin
            q_hex.push_back(hex_of(acc_model));
            @(negedge CLOCK_50);
            check("done_hold_state", 64'(LEDR), 64'd2);
            check("done_hold_hex", 64'(w_hex), 64'(q_hex.pop_front()));
        end
        SW[0] = 1'b0;
        #1;
        check("sw_off_blank", 64'(w_hex), 64'(hex_blank));

        // Reset from DONE, then again mid-EXEC, and rerun to completion.
        @(posedge CLOCK_50); #1;
        SW[0] = 1'b1;
        hold_reset(2);
        release_track(12);
        @(posedge CLOCK_50); #1;
        hold_reset(2);
        release_track(17);
        q_hex.push_back(hex_of(acc_model));
        #1;
        check("rerun_digits", 64'(w_hex), 64'(q_hex.pop_front()));
        SW[0] = 1'b0;

        // FIFO unit test.
        @(posedge CLOCK_50); #1;
        f_rst = 1'b0;
        check("fifo_empty_reset", 64'(f_empty), 64'd1);
        check("fifo_full_reset", 64'(f_full), 64'd0);
        for (int i = 0; i < 8; i++) begin
            f_din = 8'($urandom);
            f_wr  = 1'b1;
            q_fifo.push_back(f_din);
            @(posedge CLOCK_50); #1;
        end
        f_wr = 1'b0;
        check("fifo_full_after8", 64'(f_full), 64'd1);
        f_din = 8'hEE;
        f_wr  = 1'b1;
        @(posedge CLOCK_50); #1;
        f_wr = 1'b0;
        check("fifo_full_after9", 64'(f_full), 64'd1);
        for (int i = 0; i < 8; i++) begin
            f_rd = 1'b1;
            check($sformatf("fifo_pop%0d", i), 64'(f_dout), 64'(q_fifo.pop_front()));
            @(posedge CLOCK_50); #1;
        end
        f_rd = 1'b0;
        check("fifo_empty_after8", 64'(f_empty), 64'd1);
        f_rd = 1'b1;
        @(posedge CLOCK_50); #1;
        f_rd = 1'b0;
        check("fifo_empty_after9", 64'(f_empty), 64'd1);
        check("fifo_not_full", 64'(f_full), 64'd0);
        f_din = 8'h5A;
        f_wr  = 1'b1;
        @(posedge CLOCK_50); #1;
        f_wr = 1'b0;
        check("fifo_rewrite_head", 64'(f_dout), 64'h5A);
        check("fifo_rewrite_nonempty", 64'(f_empty), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/minilab0.md
MINILAB0 -- requirements
Module: minilab0

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high. The internal rst = ~KEY[0] (pushbutton pressed = low) is sampled on CLOCK_50 rising edges.
REQ-002 CLOCK_50  input  1  sole functional clock, 50 MHz.
REQ-003 KEY  input  4  KEY[0] is the reset source (low = reset asserted); KEY[3:1] are ignored.
REQ-004 CLOCK2_50, CLOCK3_50, CLOCK4_50  input  1 each  unused; the block SHALL tolerate them floating.
REQ-005 SW  input  10  SW[0] is display enable; SW[9:1] are ignored.
REQ-006 HEX0..HEX5  output  7 each  active-low seven-segment digits, bit order gfedcba; HEX0 is the least significant nibble.
REQ-007 LEDR  output  10  LEDR[1:0] = FSM state code; LEDR[9:2] = 0.

Function
REQ-008 SHALL contain two FIFOs A and B, each depth 8, width 8 bits, plus one multiply-accumulate (MAC) unit with a 24-bit accumulator.
REQ-009 FSM states and codes: FILL = 2'd0, EXEC = 2'd1, DONE = 2'd2. Code 2'd3 is unused and SHALL return to FILL.
REQ-010 FILL: each cycle, write element i (i = 0..7) into both FIFOs (A_i into A, B_i into B); after the 8th write, go to EXEC on the next edge.
REQ-011 Constant fill data: A = 5,10,15,20,25,30,35,40; B = 10,20,30,40,50,60,70,80, written in the listed order.
REQ-012 EXEC: each cycle, pop both FIFOs together and update acc <= acc + A_head*B_head. After the 8th pop (both FIFOs empty), go to DONE on the next edge; acc is final on entering DONE.
REQ-013 Product width is 16 bits unsigned, zero-extended to 24 bits; accumulation wraps modulo 2^24 (no overflow occurs with the constant data).
REQ-014 DONE: holds until reset; acc and FIFOs stay frozen; no writes or pops occur.
REQ-015 FIFO: first-word-fall-through head output. Write when full and pop when empty SHALL be ignored with state unchanged; the FSM never issues either.
REQ-016 FIFO full/empty flags are exact: full at count 8, empty at count 0. Pointers are 3-bit and wrap 7 -> 0.
REQ-017 Display: when state == DONE and SW[0] = 1, HEXn shows hex digit acc[4n+3:4n] using the standard active-low 0-F glyphs. Otherwise every HEXn = 7'h7F (blank).
REQ-018 HEX and LEDR outputs are combinational from registered state and acc, so SW[0] takes effect in the same cycle.
REQ-019 Expected final acc = 10200 = 24'h0027D8, reached in DONE 17 cycles after reset release (8 FILL + 8 EXEC + 1).

Reset
REQ-020 While rst is high at a clock edge, the block SHALL set: state = FILL, fill and exec counters = 0, acc = 0, both FIFOs empty (pointers and count 0).
REQ-021 Reset mid-FILL, mid-EXEC or in DONE SHALL restart the full sequence from FILL; partial data is discarded.
REQ-022 During reset, LEDR = 0 and all HEX outputs are blank.

Structure
REQ-023 Package minilab0_pkg SHALL hold: the state enum (FILL/EXEC/DONE), DEPTH = 8, DATA_W = 8, ACC_W = 24, and the two constant data arrays.
REQ-024 Sub-module fifo (parameterised DEPTH and DATA_W; ports clk, rst, wr_en, rd_en, din, dout, full, empty) SHALL be instantiated twice.
REQ-025 The MAC, the FSM and the seven-segment decoder (a function in the package) SHALL live in minilab0.

Verification
REQ-026 Hold KEY[0] = 0 for 2 cycles, then release -> LEDR = 0 during reset; LEDR[1:0] = 0 for the first 8 cycles after release.
REQ-027 After release, count cycles -> LEDR[1:0] = 1 for exactly 8 cycles, then LEDR[1] rises 17 cycles after release.
REQ-028 SW[0] = 1 and DONE -> HEX5..HEX0 = 1000000, 1000000, 0100100, 1111000, 0100001, 0000000 (0,0,2,7,D,8).
REQ-029 SW[0] = 0 in DONE -> all HEX = 1111111; toggling SW[0] to 1 -> the digits above appear in the same cycle.
REQ-030 Assert KEY[0] = 0 during EXEC, then release -> the sequence restarts and the final result is again 24'h0027D8.
REQ-031 Unit test of fifo: 8 writes -> full = 1 and a 9th write is ignored; 8 pops return the data in order, then empty = 1 and a 9th pop is ignored.
